// File: rtl/cmp_flag_unit.sv
// cmp_flag_unit: two-stage pipelined A-B flag generator (Z/N/V/Carry).
// Stage 1 subtracts the low halves, and stage 2 finishes the high halves.
// A valid/ready handshake on both ends allows backpressure and flush.
module cmp_flag_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [2:0]  in_funct3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        Z,
    output logic        N,
    output logic        V,
    output logic        Carry,
    output logic [2:0]  out_funct3
);

    // Stage 1 registers
    logic        s1_valid_q;
    logic [15:0] lo_q;
    logic        c16_q;
    logic        zlo_q;
    logic [15:0] a_hi_q;
    logic [15:0] b_hi_q;
    logic        a31_q;
    logic        b31_q;
    logic [2:0]  tag1_q;

    // Stage 2 registers (drive the outputs directly)
    logic        s2_valid_q;
    logic        z_q;
    logic        n_q;
    logic        v_q;
    logic        carry_q;
    logic [2:0]  tag2_q;

    // Next-state values for the data path
    logic [15:0] lo_d;
    logic        c16_d;
    logic        zlo_d;
    logic [15:0] hi_d;
    logic        carry_d;
    logic        z_d;
    logic        n_d;
    logic        v_d;

    logic        s2_load;
    logic        accept;

    // Handshake: S1 drains into S2 whenever S2 is empty or being consumed.
    // in_ready depends only on registered state and out_ready.
    assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | ~s2_valid_q | out_ready;
    assign accept   = in_valid & in_ready & ~flush;

    // Low-half subtract (A + ~B + 1) and high-half completion using the stored carry
    always_comb begin
        {c16_d, lo_d}   = {1'b0, rs1[15:0]} + {1'b0, ~rs2[15:0]} + 17'd1;
        zlo_d           = (lo_d == 16'd0);
        {carry_d, hi_d} = {1'b0, a_hi_q} + {1'b0, ~b_hi_q} + {16'd0, c16_q};
        n_d             = hi_d[15];
        z_d             = zlo_q & (hi_d == 16'd0);
        v_d             = (a31_q != b31_q) & (hi_d[15] != a31_q);
    end

    // Stage 1: load on accept, empty when drained or flushed; data held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            lo_q       <= '0;
            c16_q      <= 1'b0;
            zlo_q      <= 1'b0;
            a_hi_q     <= '0;
            b_hi_q     <= '0;
            a31_q      <= 1'b0;
            b31_q      <= 1'b0;
            tag1_q     <= '0;
        end else if (flush) begin
            s1_valid_q <= 1'b0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            lo_q       <= lo_d;
            c16_q      <= c16_d;
            zlo_q      <= zlo_d;
            a_hi_q     <= rs1[31:16];
            b_hi_q     <= rs2[31:16];
            a31_q      <= rs1[31];
            b31_q      <= rs2[31];
            tag1_q     <= in_funct3;
        end else if (s2_load) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Stage 2: flags change only on a load; an emptied stage keeps its last flags
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            z_q        <= 1'b0;
            n_q        <= 1'b0;
            v_q        <= 1'b0;
            carry_q    <= 1'b0;
            tag2_q     <= '0;
        end else if (flush) begin
            s2_valid_q <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= 1'b1;
            z_q        <= z_d;
            n_q        <= n_d;
            v_q        <= v_d;
            carry_q    <= carry_d;
            tag2_q     <= tag1_q;
        end else if (out_ready) begin
            s2_valid_q <= 1'b0;
        end
    end

    assign out_valid  = s2_valid_q;
    assign Z          = z_q;
    assign N          = n_q;
    assign V          = v_q;
    assign Carry      = carry_q;
    assign out_funct3 = tag2_q;

endmodule
